// File: rtl/tvbg_pkg.sv
// Shared types and timing constants for the tv_b_gone start conditioner.
// Default timing assumes the 8 MHz clock shared with the tv_b_gone sequencer.
package tvbg_pkg;

  // Debounce FSM states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } tvbg_state_t;

  localparam int CYCLES_PER_MS          = 8000;
  localparam int DEF_DEBOUNCE_CYCLES    = 10 * CYCLES_PER_MS;
  localparam int DEF_REPEAT_GAP_CYCLES  = 100 * CYCLES_PER_MS;

  // Bits needed to hold values 0 .. n-1 (at least 1 bit)
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/tvbg_sync2.sv
// Two-flop synchroniser for an asynchronous board input.
// RESET_VAL selects the level both flops load while reset is asserted.
module tvbg_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic d_in,
  output logic q_out
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  assign meta_d = d_in;
  assign sync_d = meta_q;
  assign q_out  = sync_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

endmodule

// File: rtl/tvbg_start_conditioner.sv
// Push-button conditioner feeding tv_b_gone start_in: synchronise, debounce,
// emit one start pulse per validated press, and flag presses lost to busy.
// Optional build macro TVBG_START_AUTOREPEAT_EN: while the button stays held,
// restart the sequencer REPEAT_GAP_CYCLES after each busy fall.
module tvbg_start_conditioner
  import tvbg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1,
  parameter int REPEAT_GAP_CYCLES = DEF_REPEAT_GAP_CYCLES
) (
  input  logic clock_in,
  input  logic resetn_in,
  input  logic button_in,
  input  logic busy_in,
  output logic start_out,
  output logic pressed_out,
  output logic dropped_out
);

  localparam int            CW       = clog2w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_GAP_CYCLES < 2) begin : g_bad_gap
    $error("REPEAT_GAP_CYCLES must be at least 2");
  end

  logic          button_norm_s;
  logic          s_s;
  logic          progress_s;
  logic          accept_s;
  logic          rep_start_s;
  tvbg_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          pressed_q, pressed_d;
  logic          start_q, start_d;
  logic          dropped_q, dropped_d;

  // Normalise so that 1 always means pressed before synchronising
  assign button_norm_s = BUTTON_ACTIVE_LOW ? ~button_in : button_in;

  tvbg_sync2 #(.RESET_VAL(1'b0)) u_sync (
    .clk_in   (clock_in),
    .rst_n_in (resetn_in),
    .d_in     (button_norm_s),
    .q_out    (s_s)
  );

  // Debounce counter, arming after reset, and the press/release FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    pressed_d = pressed_q;
    start_d   = 1'b0;
    dropped_d = 1'b0;
    // Until a stable release has been seen, only a released level makes progress
    progress_s = armed_q ? (s_s != pressed_q) : (s_s == 1'b0);
    accept_s   = progress_s && (cnt_q == CNT_LAST);
    if (!progress_s) begin
      cnt_d = {CW{1'b0}};
    end else if (accept_s) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    if (!armed_q) begin
      armed_d = accept_s;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_s) state_d = PRESS_DB;
          else     state_d = IDLE;
        end
        PRESS_DB: begin
          if (!s_s) begin
            state_d = IDLE;
          end else if (accept_s) begin
            state_d   = HELD;
            pressed_d = 1'b1;
            if (busy_in) dropped_d = 1'b1;
            else         start_d   = 1'b1;
          end else begin
            state_d = PRESS_DB;
          end
        end
        HELD: begin
          if (!s_s) state_d = RELEASE_DB;
          else      state_d = HELD;
        end
        RELEASE_DB: begin
          if (s_s) begin
            state_d = HELD;
          end else if (accept_s) begin
            state_d   = IDLE;
            pressed_d = 1'b0;
          end else begin
            state_d = RELEASE_DB;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef TVBG_START_AUTOREPEAT_EN
  localparam int            GW       = clog2w(REPEAT_GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(REPEAT_GAP_CYCLES - 1);

  logic          busy_q, busy_d;
  logic          gap_on_q, gap_on_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  // Gap timer: busy fall while held starts it, leaving HELD or busy aborts it
  always_comb begin
    busy_d      = busy_in;
    gap_on_d    = gap_on_q;
    gap_cnt_d   = gap_cnt_q;
    rep_start_s = 1'b0;
    if ((state_q != HELD) || busy_in) begin
      gap_on_d  = 1'b0;
      gap_cnt_d = {GW{1'b0}};
    end else if (busy_q) begin
      gap_on_d  = 1'b1;
      gap_cnt_d = GW'(1);
    end else if (gap_on_q && (gap_cnt_q == GAP_LAST)) begin
      rep_start_s = 1'b1;
      gap_on_d    = 1'b0;
      gap_cnt_d   = {GW{1'b0}};
    end else if (gap_on_q) begin
      gap_cnt_d = gap_cnt_q + GW'(1);
    end else begin
      gap_cnt_d = gap_cnt_q;
    end
  end

  // Gap timer state and previous busy level
  always_ff @(posedge clock_in or negedge resetn_in) begin
    if (!resetn_in) begin
      busy_q    <= 1'b0;
      gap_on_q  <= 1'b0;
      gap_cnt_q <= {GW{1'b0}};
    end else begin
      busy_q    <= busy_d;
      gap_on_q  <= gap_on_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end
`else
  assign rep_start_s = 1'b0;
`endif

  // Main state and registered outputs
  always_ff @(posedge clock_in or negedge resetn_in) begin
    if (!resetn_in) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      armed_q   <= 1'b0;
      pressed_q <= 1'b0;
      start_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      pressed_q <= pressed_d;
      start_q   <= start_d | rep_start_s;
      dropped_q <= dropped_d;
    end
  end

  assign start_out   = start_q;
  assign pressed_out = pressed_q;
  assign dropped_out = dropped_q;

endmodule
